// File: rtl/csi_frame_capture.sv
// CSI-2 image-data capture into a dual-bank frame RAM, with frame skip, single-shot/continuous
// modes, geometry error flags and display-side read-address generation.
module csi_frame_capture #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned PIX_PER_BEAT = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SKIP_FRAMES  = 2,
  parameter int unsigned DOUBLE_BUF   = 1,
  parameter int unsigned COORD_W      = 10,
  localparam int unsigned BPL = H_ACTIVE / PIX_PER_BEAT,
  localparam int unsigned WA  = $clog2(V_ACTIVE * BPL),
  localparam int unsigned AW  = DOUBLE_BUF + WA,
  localparam int unsigned LW  = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               arm,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               line_start,
  input  logic               line_end,
  input  logic               data_valid,
  input  logic [DATA_W-1:0]  data,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic [AW-1:0]      rd_addr,
  output logic [LW-1:0]      rd_lane,
  output logic               frame_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               err_overrun,
  output logic               err_short
);

  localparam int unsigned FW = V_ACTIVE * BPL;
  localparam int unsigned CW = $clog2(BPL + 1);
  localparam int unsigned RW = $clog2(V_ACTIVE + 1);
  localparam int unsigned NW = $clog2(FW + 2);
  localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int unsigned SH = $clog2(PIX_PER_BEAT);

  localparam logic [CW-1:0] BPL_C  = CW'(BPL);
  localparam logic [RW-1:0] V_C    = RW'(V_ACTIVE);
  localparam logic [NW-1:0] FW_C   = NW'(FW);
  localparam logic [SW-1:0] SKIP_C = SW'(SKIP_FRAMES);
  localparam logic [WA-1:0] BPL_W  = WA'(BPL);
  localparam logic          DB     = (DOUBLE_BUF != 0);

  typedef enum logic [2:0] {IDLE, SKIP, WAIT_FS, CAPTURE, DONE} state_t;

  state_t        state;
  logic          wbank;
  logic          display_bank;
  logic          armed;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NW-1:0] wcount;
  logic [SW-1:0] skip_cnt;

  logic          beat_ok;
  logic [WA-1:0] widx;
  logic [NW-1:0] wc_next;
  logic [WA-1:0] rd_word;

  // The written count saturates one past a full frame so over-long frames never alias to "full".
  always_comb begin
    beat_ok = data_valid && (col < BPL_C) && (row < V_C);
    widx    = WA'(row) * BPL_W + WA'(col);
    wc_next = (beat_ok && (wcount <= FW_C)) ? wcount + 1'b1 : wcount;
    rd_word = WA'(rd_y) * BPL_W + WA'(rd_x >> SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wbank        <= 1'b0;
      display_bank <= DB;
      armed        <= 1'b0;
      col          <= '0;
      row          <= '0;
      wcount       <= '0;
      skip_cnt     <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_addr      <= '0;
      rd_lane      <= '0;
      frame_valid  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      err_overrun  <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      rd_addr    <= AW'({display_bank, rd_word});
      rd_lane    <= (PIX_PER_BEAT > 1) ? LW'(rd_x) : '0;

      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (arm)
          armed <= 1'b1;
        unique case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (SKIP_FRAMES == 0) ? WAIT_FS : SKIP;
          end
          SKIP: begin
            if (frame_end) begin
              skip_cnt <= skip_cnt + 1'b1;
              if (skip_cnt == SKIP_C - 1'b1)
                state <= WAIT_FS;
            end
          end
          WAIT_FS: begin
            if (frame_start && (mode || armed)) begin
              state  <= CAPTURE;
              busy   <= 1'b1;
              armed  <= 1'b0;
              col    <= '0;
              row    <= '0;
              wcount <= '0;
            end
          end
          CAPTURE: begin
            if (frame_start) begin
              col       <= '0;
              row       <= '0;
              wcount    <= '0;
              err_short <= 1'b1;
            end else begin
              // Beat uses the current position; line markers then reposition for the next beat.
              if (data_valid) begin
                if (beat_ok) begin
                  wr_en   <= 1'b1;
                  wr_addr <= AW'({wbank, widx});
                  wr_data <= data;
                  col     <= col + 1'b1;
                end else begin
                  err_overrun <= 1'b1;
                end
              end
              wcount <= wc_next;
              if (line_start)
                col <= '0;
              if (line_end) begin
                col <= '0;
                if (row < V_C)
                  row <= row + 1'b1;
              end
              if (frame_end) begin
                if (wc_next == FW_C) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  frame_valid <= 1'b1;
                  if (DB) begin
                    display_bank <= wbank;
                    wbank        <= ~wbank;
                  end
                end else begin
                  err_short <= 1'b1;
                end
                state <= mode ? WAIT_FS : DONE;
                busy  <= 1'b0;
              end
            end
          end
          DONE: begin
            if (arm)
              state <= WAIT_FS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
